// File: rtl/id_stage.sv
// id_stage: instruction decode stage of the 5-stage MIPS core.
//   Holds the 32x32 general register file, decodes the instruction latched
//   from fetch, stalls on RAW hazards against execute/memory/writeback (no
//   forwarding), and resolves branches/jumps back to fetch via br_bus.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   es_allowin        execute stage can accept
//   ds_allowin        decode stage can accept
//   fs_to_ds_valid    fetch output valid
//   fs_to_ds_bus      {pc[63:32], inst[31:0]}
//   ds_to_es_valid    decode output valid
//   ds_to_es_bus      {alu_op[12], load_op, src1_is_sa, src1_is_pc,
//                      src2_is_imm, src2_is_8, gr_we, mem_we,
//                      dest[5], imm[16], rs_value[32], rt_value[32], pc[32]}
//   br_bus            {br_taken, br_target} to fetch
//   ws_to_rf_bus      {rf_we, rf_waddr[5], rf_wdata[32]} from writeback
//   es_dest/ms_dest/ws_dest  pending write destinations (0 if none)
module id_stage #(
    parameter int XLEN            = 32,
    parameter int FS_TO_DS_BUS_WD = 64,
    parameter int DS_TO_ES_BUS_WD = 136,
    parameter int WS_TO_RF_BUS_WD = 38,
    parameter int BR_BUS_WD       = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_allowin,
    output logic                       ds_allowin,
    input  logic                       fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic [BR_BUS_WD-1:0]       br_bus,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    input  logic [4:0]                 es_dest,
    input  logic [4:0]                 ms_dest,
    input  logic [4:0]                 ws_dest
);

    // ---------------- pipeline register ----------------
    logic            ds_valid;
    logic            ds_ready_go;
    logic [XLEN-1:0] ds_pc;
    logic [XLEN-1:0] ds_inst;

    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_pc    <= '0;
            ds_inst  <= '0;
        end else begin
            if (ds_allowin)
                ds_valid <= fs_to_ds_valid;
            if (ds_allowin && fs_to_ds_valid)
                {ds_pc, ds_inst} <= fs_to_ds_bus;
        end
    end

    // ---------------- register file ----------------
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] rf [32];

    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0)
            rf[rf_waddr] <= rf_wdata;
    end

    // ---------------- field extraction ----------------
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jidx;

    assign op   = ds_inst[31:26];
    assign rs   = ds_inst[25:21];
    assign rt   = ds_inst[20:16];
    assign rd   = ds_inst[15:11];
    assign func = ds_inst[5:0];
    assign imm  = ds_inst[15:0];
    assign jidx = ds_inst[25:0];

    logic [XLEN-1:0] rs_value, rt_value;
    assign rs_value = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_value = (rt == 5'd0) ? '0 : rf[rt];

    // ---------------- instruction decode ----------------
    logic op_special;
    logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or;
    logic inst_xor, inst_nor, inst_sll, inst_srl, inst_sra, inst_jr;
    logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;

    assign op_special = (op == 6'h00);
    assign inst_addu  = op_special & (func == 6'h21);
    assign inst_subu  = op_special & (func == 6'h23);
    assign inst_slt   = op_special & (func == 6'h2a);
    assign inst_sltu  = op_special & (func == 6'h2b);
    assign inst_and   = op_special & (func == 6'h24);
    assign inst_or    = op_special & (func == 6'h25);
    assign inst_xor   = op_special & (func == 6'h26);
    assign inst_nor   = op_special & (func == 6'h27);
    assign inst_sll   = op_special & (func == 6'h00);
    assign inst_srl   = op_special & (func == 6'h02);
    assign inst_sra   = op_special & (func == 6'h03);
    assign inst_jr    = op_special & (func == 6'h08);
    assign inst_addiu = (op == 6'h09);
    assign inst_lui   = (op == 6'h0f);
    assign inst_lw    = (op == 6'h23);
    assign inst_sw    = (op == 6'h2b);
    assign inst_beq   = (op == 6'h04);
    assign inst_bne   = (op == 6'h05);
    assign inst_jal   = (op == 6'h03);

    logic is_rtype_alu, is_shift, dst_is_rd, dst_is_rt;
    assign is_rtype_alu = inst_addu | inst_subu | inst_slt | inst_sltu |
                          inst_and  | inst_or   | inst_xor | inst_nor;
    assign is_shift     = inst_sll | inst_srl | inst_sra;
    assign dst_is_rd    = is_rtype_alu | is_shift;
    assign dst_is_rt    = inst_addiu | inst_lui | inst_lw;

    logic [11:0] alu_op;
    logic        load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8;
    logic        gr_we, mem_we;
    logic [4:0]  dest;

    // JAL computes its link value as pc + 8 through the ALU adder.
    assign alu_op = {inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal,
                     inst_subu, inst_slt, inst_sltu, inst_and, inst_nor,
                     inst_or, inst_xor, inst_sll, inst_srl, inst_sra, inst_lui};
    assign load_op     = inst_lw;
    assign src1_is_sa  = is_shift;
    assign src1_is_pc  = inst_jal;
    assign src2_is_imm = inst_addiu | inst_lui | inst_lw | inst_sw;
    assign src2_is_8   = inst_jal;
    assign gr_we       = dst_is_rd | dst_is_rt | inst_jal;
    assign mem_we      = inst_sw;
    // Non-writing instructions report dest 0 so downstream hazard checks ignore them.
    assign dest = inst_jal  ? 5'd31 :
                  dst_is_rt ? rt    :
                  dst_is_rd ? rd    : 5'd0;

    assign ds_to_es_bus = {alu_op, load_op, src1_is_sa, src1_is_pc, src2_is_imm,
                           src2_is_8, gr_we, mem_we, dest, imm,
                           rs_value, rt_value, ds_pc};

    // ---------------- RAW hazard ----------------
    logic rs_used, rt_used, rs_hit, rt_hit, stall;
    assign rs_used = is_rtype_alu | inst_addiu | inst_lw | inst_sw |
                     inst_beq | inst_bne | inst_jr;
    assign rt_used = is_rtype_alu | is_shift | inst_sw | inst_beq | inst_bne;
    assign rs_hit  = (rs != 5'd0) && (rs == es_dest || rs == ms_dest || rs == ws_dest);
    assign rt_hit  = (rt != 5'd0) && (rt == es_dest || rt == ms_dest || rt == ws_dest);
    assign stall   = ds_valid & ((rs_used & rs_hit) | (rt_used & rt_hit));
    assign ds_ready_go = ~stall;

    // ---------------- branch resolution ----------------
    logic            rs_eq_rt, br_taken;
    logic [XLEN-1:0] pc_plus4, br_offs, br_target;
    assign rs_eq_rt = (rs_value == rt_value);
    assign pc_plus4 = ds_pc + 32'd4;
    assign br_offs  = {{14{imm[15]}}, imm, 2'b00};
    assign br_taken = ds_valid & ds_ready_go &
                      ((inst_beq & rs_eq_rt) | (inst_bne & ~rs_eq_rt) | inst_jal | inst_jr);
    // Target is zeroed when not taken so br_bus reads all-zero when idle.
    assign br_target = ~br_taken ? '0 :
                       inst_jr   ? rs_value :
                       inst_jal  ? {pc_plus4[31:28], jidx, 2'b00} :
                                   pc_plus4 + br_offs;
    assign br_bus = {br_taken, br_target};

endmodule
